mc_seq_ctrl: RTL and testbench

- Multicycle control sequencer for the 16-bit pmips core.
- Owns the PC and instruction register and drives the instruction-memory address.
- Decodes the 3-bit opcode and generates register-file, ALU and data-memory strobes.
- Sits between the instruction memory (combinational, 16-bit) and the register file/ALU/data-memory datapath.

---
 rtl/mc_seq_ctrl_if.sv | 33 +++
 rtl/mc_seq_ctrl.sv | 169 ++++++++++++++++
 tb/tb_mc_seq_ctrl.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/mc_seq_ctrl_if.sv
// Sequencer-to-datapath bundle for mc_seq_ctrl: instruction fetch, register file,
// ALU control, data-memory handshake and debug state.
interface mc_seq_ctrl_if;
   logic [15:0] iaddr;
   logic [15:0] idata;
   logic [15:0] ir;
   logic [2:0]  rf_ra;
   logic [2:0]  rf_rb;
   logic [2:0]  rf_waddr;
   logic        rf_we;
   logic [15:0] imm;
   logic [3:0]  alu_op;
   logic        alu_src_imm;
   logic        alu_zero;
   logic        mem_rd;
   logic        mem_wr;
   logic        mem_ready;
   logic        wb_sel_mem;
   logic        halted;
   logic [2:0]  state;

   modport master (
      output iaddr, ir, rf_ra, rf_rb, rf_waddr, rf_we, imm, alu_op, alu_src_imm,
             mem_rd, mem_wr, wb_sel_mem, halted, state,
      input  idata, alu_zero, mem_ready
   );

   modport slave (
      input  iaddr, ir, rf_ra, rf_rb, rf_waddr, rf_we, imm, alu_op, alu_src_imm,
             mem_rd, mem_wr, wb_sel_mem, halted, state,
      output idata, alu_zero, mem_ready
   );
endinterface

// File: rtl/mc_seq_ctrl.sv
// Multicycle control sequencer for the 16-bit pmips core: owns PC/IR, decodes, drives strobes.
// Optional single-step input enabled by defining MC_SEQ_CTRL_STEP_EN.
module mc_seq_ctrl #(
   parameter logic [15:0] RESET_PC = 16'h0000,
   parameter logic [3:0]  ALU_ADD  = 4'd3,
   parameter logic [3:0]  ALU_SUB  = 4'd1
) (
   input  logic          clock,
   input  logic          reset_n,
   input  logic          run,
`ifdef MC_SEQ_CTRL_STEP_EN
   input  logic          step,
`endif
   mc_seq_ctrl_if.master bus
);

   typedef enum logic [2:0] {
      FETCH  = 3'd0,
      DECODE = 3'd1,
      EXEC   = 3'd2,
      MEM    = 3'd3,
      WB     = 3'd4,
      HALT   = 3'd5
   } state_t;

   typedef enum logic [2:0] {
      OP_R    = 3'd0,
      OP_LW   = 3'd1,
      OP_SW   = 3'd2,
      OP_ADDI = 3'd3,
      OP_BEQ  = 3'd4,
      OP_BNE  = 3'd5,
      OP_HALT = 3'd6,
      OP_JMP  = 3'd7
   } opcode_t;

   state_t      st;
   logic [15:0] pc;
   logic [15:0] ir_q;

   opcode_t     op;
   logic [15:0] imm_sx;
   logic [15:0] pc_inc;
   logic [15:0] br_target;
   logic [15:0] jmp_target;
   logic [2:0]  waddr;
   logic        br_taken;
   logic        fetch_go;

   logic [3:0]  alu_op_c;
   logic        alu_src_imm_c;
   logic        mem_rd_c;
   logic        mem_wr_c;
   logic        rf_we_c;
   logic        wb_sel_mem_c;

   assign op         = opcode_t'(ir_q[15:13]);
   assign imm_sx     = {{9{ir_q[6]}}, ir_q[6:0]};
   assign pc_inc     = pc + 16'd2;
   // pc already points past the branch, so the offset is relative to the next word
   assign br_target  = pc + (imm_sx << 1);
   assign jmp_target = {pc[15:14], ir_q[12:0], 1'b0};
   assign waddr      = (op == OP_R) ? ir_q[6:4] : ir_q[9:7];
   assign br_taken   = ((op == OP_BEQ) &&  bus.alu_zero) ||
                       ((op == OP_BNE) && !bus.alu_zero);

`ifdef MC_SEQ_CTRL_STEP_EN
   logic step_q;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) step_q <= 1'b0;
      else          step_q <= step;
   end

   // edges seen outside FETCH are simply not consumed
   assign fetch_go = run & step & ~step_q;
`else
   assign fetch_go = run;
`endif

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         st   <= FETCH;
         pc   <= RESET_PC;
         ir_q <= '0;
      end else begin
         case (st)
            FETCH: begin
               if (fetch_go) begin
                  ir_q <= bus.idata;
                  pc   <= pc_inc;
                  st   <= DECODE;
               end
            end
            DECODE: st <= (op == OP_HALT) ? HALT : EXEC;
            EXEC: begin
               case (op)
                  OP_R, OP_ADDI: st <= WB;
                  OP_LW, OP_SW:  st <= MEM;
                  OP_BEQ, OP_BNE: begin
                     if (br_taken) pc <= br_target;
                     st <= FETCH;
                  end
                  OP_JMP: begin
                     pc <= jmp_target;
                     st <= FETCH;
                  end
                  default: st <= FETCH;
               endcase
            end
            MEM: begin
               if (bus.mem_ready) st <= (op == OP_LW) ? WB : FETCH;
            end
            WB:      st <= FETCH;
            HALT:    st <= HALT;
            default: st <= FETCH;
         endcase
      end
   end

   always_comb begin
      alu_op_c      = '0;
      alu_src_imm_c = 1'b0;
      mem_rd_c      = 1'b0;
      mem_wr_c      = 1'b0;
      rf_we_c       = 1'b0;
      wb_sel_mem_c  = 1'b0;
      case (st)
         EXEC: begin
            case (op)
               OP_R: alu_op_c = ir_q[3:0];
               OP_LW, OP_SW, OP_ADDI: begin
                  alu_op_c      = ALU_ADD;
                  alu_src_imm_c = 1'b1;
               end
               OP_BEQ, OP_BNE: alu_op_c = ALU_SUB;
               default: ;
            endcase
         end
         MEM: begin
            alu_op_c      = ALU_ADD;
            alu_src_imm_c = 1'b1;
            mem_rd_c      = (op == OP_LW);
            mem_wr_c      = (op == OP_SW);
         end
         WB: begin
            rf_we_c      = (waddr != 3'd0);
            wb_sel_mem_c = (op == OP_LW);
         end
         default: ;
      endcase
   end

   assign bus.iaddr       = pc;
   assign bus.ir          = ir_q;
   assign bus.rf_ra       = ir_q[12:10];
   assign bus.rf_rb       = ir_q[9:7];
   assign bus.rf_waddr    = waddr;
   assign bus.rf_we       = rf_we_c;
   assign bus.imm         = imm_sx;
   assign bus.alu_op      = alu_op_c;
   assign bus.alu_src_imm = alu_src_imm_c;
   assign bus.mem_rd      = mem_rd_c;
   assign bus.mem_wr      = mem_wr_c;
   assign bus.wb_sel_mem  = wb_sel_mem_c;
   assign bus.halted      = (st == HALT);
   assign bus.state       = st;

endmodule

// File: tb/tb_mc_seq_ctrl.sv
// Self-checking bench for mc_seq_ctrl: directed program, random instruction stream,
// reset during MEM, PC wrap and halt, compared against an instruction-level model.
module tb_mc_seq_ctrl;
   logic clock = 1'b0;
   logic reset_n;
   logic run;
`ifdef MC_SEQ_CTRL_STEP_EN
   logic step;
`endif

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   logic [15:0] imem [0:32767];
   logic [15:0] pc;

   mc_seq_ctrl_if bus ();

   mc_seq_ctrl #(
      .RESET_PC (16'h0000),
      .ALU_ADD  (4'd3),
      .ALU_SUB  (4'd1)
   ) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .run     (run),
`ifdef MC_SEQ_CTRL_STEP_EN
      .step    (step),
`endif
      .bus     (bus)
   );

   always #5 clock = ~clock;

   assign bus.idata = imem[bus.iaddr[15:1]];

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Runs one instruction starting at a negedge with the DUT in FETCH; the model
   // works from the architectural rules (latency, next PC, writes, memory cycles).
   task automatic exec_one(input logic zero, input int unsigned waits);
      logic [15:0] ins, imm, pc2, npc;
      logic [2:0]  op, dest;
      logic [3:0]  exp_alu;
      int unsigned cyc, exp_we, exp_rd, exp_wr, exp_src, exp_wbs;
      int unsigned we_n, rd_n, wr_n, wbs_n, src_n, halt_n, mcnt;
      logic [2:0]  we_addr;
      ins  = imem[pc[15:1]];
      op   = ins[15:13];
      imm  = {{9{ins[6]}}, ins[6:0]};
      pc2  = pc + 16'd2;
      npc  = pc2;
      dest = (op == 3'd0) ? ins[6:4] : ins[9:7];
      case (op)
         3'd0, 3'd3: cyc = 4;
         3'd1:       cyc = 5 + waits;
         3'd2:       cyc = 4 + waits;
         default:    cyc = 3;
      endcase
      if ((op == 3'd4 && zero) || (op == 3'd5 && !zero)) npc = pc2 + (imm << 1);
      if (op == 3'd7) npc = {pc2[15:14], ins[12:0], 1'b0};
      exp_we  = ((op == 3'd0 || op == 3'd1 || op == 3'd3) && dest != 3'd0) ? 1 : 0;
      exp_rd  = (op == 3'd1) ? waits + 1 : 0;
      exp_wr  = (op == 3'd2) ? waits + 1 : 0;
      exp_wbs = (op == 3'd1) ? 1 : 0;
      exp_src = (op == 3'd3) ? 1 : (op == 3'd1 || op == 3'd2) ? waits + 2 : 0;
      exp_alu = (op == 3'd0) ? ins[3:0] : (op <= 3'd3) ? 4'd3 : 4'd1;
      we_n = 0; rd_n = 0; wr_n = 0; wbs_n = 0; src_n = 0; halt_n = 0; mcnt = 0;
      we_addr = '0;
      bus.alu_zero = zero;
`ifdef MC_SEQ_CTRL_STEP_EN
      step = 1'b1;
`endif
      for (int k = 0; k < int'(cyc); k++) begin
         if (k == 0) begin
            check_eq("fetch_iaddr", bus.iaddr, pc);
            check_eq("fetch_state", bus.state, 0);
         end
         if (k == 1) begin
            check_eq("decode_ir", bus.ir, ins);
            check_eq("decode_imm", bus.imm, imm);
            check_eq("decode_ra", bus.rf_ra, ins[12:10]);
            check_eq("decode_rb", bus.rf_rb, ins[9:7]);
         end
         if (k == 2 && op != 3'd7) begin
            check_eq("exec_alu_op", bus.alu_op, exp_alu);
            check_eq("exec_src_imm", bus.alu_src_imm, (op == 3'd1 || op == 3'd2 || op == 3'd3));
         end
         if (bus.mem_rd || bus.mem_wr) begin
            bus.mem_ready = (mcnt >= waits);
            mcnt++;
         end else begin
            bus.mem_ready = 1'b0;
         end
         if (bus.rf_we) begin
            we_n++;
            we_addr = bus.rf_waddr;
         end
         rd_n   += bus.mem_rd;
         wr_n   += bus.mem_wr;
         wbs_n  += bus.wb_sel_mem;
         src_n  += bus.alu_src_imm;
         halt_n += bus.halted;
         @(posedge clock);
         @(negedge clock);
`ifdef MC_SEQ_CTRL_STEP_EN
         step = 1'b0;
`endif
      end
      bus.mem_ready = 1'b0;
      check_eq("end_state", bus.state, 0);
      check_eq("next_iaddr", bus.iaddr, npc);
      check_eq("rf_we_count", we_n, exp_we);
      if (exp_we != 0) check_eq("rf_waddr", we_addr, dest);
      check_eq("mem_rd_cycles", rd_n, exp_rd);
      check_eq("mem_wr_cycles", wr_n, exp_wr);
      check_eq("wb_sel_cycles", wbs_n, exp_wbs);
      if (op != 3'd7) check_eq("src_imm_cycles", src_n, exp_src);
      check_eq("halted_low", halt_n, 0);
      pc = npc;
   endtask

   initial begin
      logic [31:0] r;
      logic [2:0]  rop;
      for (int i = 0; i < 32768; i++) begin
         r   = $urandom;
         rop = r[15:13];
         if (rop == 3'd6) rop = 3'd3;
         imem[i] = {rop, r[12:0]};
      end
      imem[0] = 16'h6083;   // addi $1,$0,3
      imem[1] = 16'h0043;   // add  $4,$0,$0
      imem[2] = 16'hE008;   // jmp 0x0010
      imem[7] = 16'hE008;   // 0x000E: jmp 0x0010
      imem[8] = 16'h807E;   // 0x0010: beq offset -2
      imem[9] = 16'h2505;   // 0x0012: lw $2,5($1)

      reset_n = 1'b0;
      run = 1'b0;
      bus.alu_zero = 1'b0;
      bus.mem_ready = 1'b0;
`ifdef MC_SEQ_CTRL_STEP_EN
      step = 1'b0;
`endif
      repeat (2) @(negedge clock);
      check_eq("rst_iaddr", bus.iaddr, 16'h0000);
      check_eq("rst_ir", bus.ir, 16'h0000);
      check_eq("rst_state", bus.state, 0);
      check_eq("rst_halted", bus.halted, 0);
      check_eq("rst_alu_op", bus.alu_op, 0);
      check_eq("rst_strobes", {bus.rf_we, bus.mem_rd, bus.mem_wr, bus.wb_sel_mem, bus.alu_src_imm}, 0);
      reset_n = 1'b1;

      repeat (3) @(negedge clock);
      check_eq("idle_iaddr", bus.iaddr, 16'h0000);
      check_eq("idle_state", bus.state, 0);
      check_eq("idle_ir", bus.ir, 16'h0000);
      run = 1'b1;
`ifdef MC_SEQ_CTRL_STEP_EN
      repeat (3) @(negedge clock);
      check_eq("nostep_iaddr", bus.iaddr, 16'h0000);
      check_eq("nostep_state", bus.state, 0);
`endif

      pc = 16'h0000;
      exec_one(1'b0, 0);   // addi
      exec_one(1'b0, 0);   // add
      exec_one(1'b0, 0);   // jmp -> 0010
      exec_one(1'b1, 0);   // beq taken -> 000E
      exec_one(1'b0, 0);   // jmp -> 0010
      exec_one(1'b0, 0);   // beq not taken -> 0012
      exec_one(1'b0, 3);   // lw, three waits

      for (int n = 0; n < 300; n++)
         exec_one(1'($urandom_range(0, 1)), $urandom_range(0, 3));

      // reset while a load sits in MEM
      imem[pc[15:1]] = 16'h2505;
      bus.alu_zero = 1'b0;
`ifdef MC_SEQ_CTRL_STEP_EN
      step = 1'b1;
`endif
      repeat (3) begin
         @(posedge clock);
         @(negedge clock);
`ifdef MC_SEQ_CTRL_STEP_EN
         step = 1'b0;
`endif
      end
      check_eq("mid_mem_state", bus.state, 3);
      check_eq("mid_mem_rd", bus.mem_rd, 1);
      #2 reset_n = 1'b0;
      #1;
      check_eq("async_rst_state", bus.state, 0);
      check_eq("async_rst_mem_rd", bus.mem_rd, 0);
      check_eq("async_rst_iaddr", bus.iaddr, 16'h0000);
      check_eq("async_rst_alu", {bus.alu_op, bus.alu_src_imm}, 0);

      imem[0]       = 16'h807E;   // beq -2 from 0000 -> FFFE
      imem[16'h7FFF] = 16'hE020;  // FFFE: jmp, PC wraps so target is 0040
      imem[16'h0020] = 16'hC000;  // 0040: halt
      @(negedge clock);
      reset_n = 1'b1;
      pc = 16'h0000;
      exec_one(1'b1, 0);
      exec_one(1'b0, 0);

      check_eq("halt_fetch_iaddr", bus.iaddr, 16'h0040);
`ifdef MC_SEQ_CTRL_STEP_EN
      step = 1'b1;
`endif
      @(posedge clock);
      @(negedge clock);
`ifdef MC_SEQ_CTRL_STEP_EN
      step = 1'b0;
`endif
      check_eq("halt_decode_state", bus.state, 1);
      for (int n = 0; n < 8; n++) begin
         @(posedge clock);
         @(negedge clock);
         check_eq("halt_state", bus.state, 5);
         check_eq("halt_flag", bus.halted, 1);
         check_eq("halt_iaddr", bus.iaddr, 16'h0042);
         check_eq("halt_strobes", {bus.rf_we, bus.mem_rd, bus.mem_wr}, 0);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
